// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM encoding, bubble instruction
// and the sequential PC increment.
package fetch_unit_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC        = 4;

    // States in which the fetch stage may present a read request.
    function automatic logic is_issue_state(input logic [1:0] st);
        return (st == ST_BOOT) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction that returns from memory
// while decode is stalled; clear has priority over write.
module fetch_skid_buf
    import fetch_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_instr,
    input  logic [ADDR_W-1:0] wr_pc4,
    output logic              full,
    output logic [DATA_W-1:0] rd_instr,
    output logic [ADDR_W-1:0] rd_pc4
);

    logic              full_r;
    logic [DATA_W-1:0] instr_r;
    logic [ADDR_W-1:0] pc4_r;

    // Entry capture and release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full_r  <= 1'b0;
            instr_r <= DATA_W'(NOP_INSTR_DEF);
            pc4_r   <= {ADDR_W{1'b0}};
        end else if (clr) begin
            full_r  <= 1'b0;
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
        end else if (wr_en) begin
            full_r  <= 1'b1;
            instr_r <= wr_instr;
            pc4_r   <= wr_pc4;
        end else begin
            full_r  <= full_r;
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
        end
    end

    assign full     = full_r;
    assign rd_instr = instr_r;
    assign rd_pc4   = pc4_r;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, 1-cycle-latency instruction memory port and
// IF/ID register, with redirect/squash, stall skid buffer and missing-response replay.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                IMEM_AW   = 7,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               stall_i,
    input  logic               pc_src_i,
    input  logic [ADDR_W-1:0]  br_addr_i,
    output logic               imem_rd_en_o,
    output logic [IMEM_AW-1:0] imem_rd_addr_o,
    input  logic [DATA_W-1:0]  imem_data_i,
    input  logic               imem_valid_i,
    output logic               ifid_valid_o,
    output logic [DATA_W-1:0]  ifid_instr_o,
    output logic [ADDR_W-1:0]  ifid_pc4_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(2'd3));
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);

    logic [1:0]        state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic [ADDR_W-1:0] req_pc_r;
    logic              req_live_r, req_live_nxt_s;
    logic              ifid_valid_r, ifid_valid_nxt_s;
    logic [DATA_W-1:0] ifid_instr_r, ifid_instr_nxt_s;
    logic [ADDR_W-1:0] ifid_pc4_r, ifid_pc4_nxt_s;

    logic              issue_s, resp_s, miss_s;
    logic [ADDR_W-1:0] pc_plus4_s, req_pc4_s, br_tgt_s;
    logic              skid_wr_s, skid_clr_s, skid_full_s;
    logic [DATA_W-1:0] skid_instr_s;
    logic [ADDR_W-1:0] skid_pc4_s;

    assign pc_plus4_s = pc_r + PC_STEP;
    assign req_pc4_s  = req_pc_r + PC_STEP;
    assign br_tgt_s   = br_addr_i & ALIGN_MASK;
    assign resp_s     = req_live_r & imem_valid_i;
    assign miss_s     = req_live_r & ~imem_valid_i;

    // Request issue: BOOT always fetches, RUN fetches unless decode is stalled.
    always_comb begin
        issue_s = 1'b0;
        if (!RST_N) begin
            issue_s = 1'b0;
        end else if (state_r == ST_RUN) begin
            issue_s = ~stall_i;
        end else begin
            issue_s = is_issue_state(state_r);
        end
    end

    assign imem_rd_en_o   = issue_s;
    assign imem_rd_addr_o = issue_s ? pc_r[IMEM_AW+1:2] : {IMEM_AW{1'b0}};

    // Next-state, PC, request tracking and IF/ID selection.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        req_live_nxt_s   = 1'b0;
        ifid_valid_nxt_s = ifid_valid_r;
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_pc4_nxt_s   = ifid_pc4_r;
        skid_wr_s        = 1'b0;
        skid_clr_s       = 1'b0;
        if (pc_src_i) begin
            // A redirect from a later stage flushes everything, even under stall.
            state_nxt_s      = ST_RUN;
            pc_nxt_s         = br_tgt_s;
            skid_clr_s       = 1'b1;
            ifid_valid_nxt_s = 1'b0;
            ifid_instr_nxt_s = NOP_INSTR;
            ifid_pc4_nxt_s   = {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_nxt_s      = ST_RUN;
                    pc_nxt_s         = pc_plus4_s;
                    req_live_nxt_s   = 1'b1;
                    ifid_valid_nxt_s = 1'b0;
                    ifid_instr_nxt_s = NOP_INSTR;
                    ifid_pc4_nxt_s   = {ADDR_W{1'b0}};
                end
                ST_RUN: begin
                    if (stall_i) begin
                        state_nxt_s = ST_HOLD;
                        skid_wr_s   = resp_s;
                        pc_nxt_s    = miss_s ? req_pc_r : pc_r;
                    end else if (miss_s) begin
                        // Drop this cycle's issue; the lost address is refetched next cycle.
                        pc_nxt_s         = req_pc_r;
                        ifid_valid_nxt_s = 1'b0;
                        ifid_instr_nxt_s = NOP_INSTR;
                        ifid_pc4_nxt_s   = {ADDR_W{1'b0}};
                    end else begin
                        pc_nxt_s         = pc_plus4_s;
                        req_live_nxt_s   = 1'b1;
                        ifid_valid_nxt_s = resp_s;
                        ifid_instr_nxt_s = resp_s ? imem_data_i : NOP_INSTR;
                        ifid_pc4_nxt_s   = resp_s ? req_pc4_s : {ADDR_W{1'b0}};
                    end
                end
                ST_HOLD: begin
                    if (stall_i) begin
                        state_nxt_s = ST_HOLD;
                        skid_wr_s   = resp_s;
                    end else begin
                        state_nxt_s      = ST_RUN;
                        skid_clr_s       = 1'b1;
                        ifid_valid_nxt_s = skid_full_s;
                        ifid_instr_nxt_s = skid_full_s ? skid_instr_s : NOP_INSTR;
                        ifid_pc4_nxt_s   = skid_full_s ? skid_pc4_s : {ADDR_W{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s      = ST_BOOT;
                    pc_nxt_s         = RESET_PC & ALIGN_MASK;
                    ifid_valid_nxt_s = 1'b0;
                    ifid_instr_nxt_s = NOP_INSTR;
                    ifid_pc4_nxt_s   = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // State, PC, in-flight request and IF/ID registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC & ALIGN_MASK;
            req_live_r   <= 1'b0;
            req_pc_r     <= {ADDR_W{1'b0}};
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc4_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            req_live_r   <= req_live_nxt_s;
            req_pc_r     <= issue_s ? pc_r : req_pc_r;
            ifid_valid_r <= ifid_valid_nxt_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_pc4_r   <= ifid_pc4_nxt_s;
        end
    end

    fetch_skid_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (skid_clr_s),
        .wr_en    (skid_wr_s),
        .wr_instr (imem_data_i),
        .wr_pc4   (req_pc4_s),
        .full     (skid_full_s),
        .rd_instr (skid_instr_s),
        .rd_pc4   (skid_pc4_s)
    );

    assign ifid_valid_o = ifid_valid_r;
    assign ifid_instr_o = ifid_instr_r;
    assign ifid_pc4_o   = ifid_pc4_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle instruction memory model
// holding mem[k] = 32'h1000_0000 + k.
module tb_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic        stall_i;
    logic        pc_src_i;
    logic [31:0] br_addr_i;
    logic        imem_rd_en_o;
    logic [6:0]  imem_rd_addr_o;
    logic [31:0] imem_data_i;
    logic        imem_valid_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;

    logic [31:0] mem [0:127];
    logic        mem_drop;
    int          checks;
    int          errors;

    fetch_unit #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .IMEM_AW   (7),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .stall_i        (stall_i),
        .pc_src_i       (pc_src_i),
        .br_addr_i      (br_addr_i),
        .imem_rd_en_o   (imem_rd_en_o),
        .imem_rd_addr_o (imem_rd_addr_o),
        .imem_data_i    (imem_data_i),
        .imem_valid_i   (imem_valid_i),
        .ifid_valid_o   (ifid_valid_o),
        .ifid_instr_o   (ifid_instr_o),
        .ifid_pc4_o     (ifid_pc4_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory: data and valid one cycle after an enabled request.
    always @(posedge CLK) begin
        if (imem_rd_en_o && !mem_drop) begin
            imem_valid_i <= 1'b1;
            imem_data_i  <= mem[imem_rd_addr_o];
        end else begin
            imem_valid_i <= 1'b0;
            imem_data_i  <= 32'hDEAD_BEEF;
        end
    end

    function automatic logic [31:0] word(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic en, input logic [31:0] addr);
        chk({tag, ".rd_en"}, 32'(imem_rd_en_o), 32'(en));
        chk({tag, ".rd_addr"}, 32'(imem_rd_addr_o), addr);
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] p4);
        chk({tag, ".valid"}, 32'(ifid_valid_o), 32'(v));
        chk({tag, ".instr"}, ifid_instr_o, ins);
        if (v) chk({tag, ".pc4"}, ifid_pc4_o, p4);
    endtask

    task automatic chk_reset(input string tag);
        chk_req(tag, 1'b0, 32'd0);
        chk({tag, ".valid"}, 32'(ifid_valid_o), 32'd0);
        chk({tag, ".instr"}, ifid_instr_o, 32'h0000_0000);
        chk({tag, ".pc4"}, ifid_pc4_o, 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        stall_i   = 1'b0;
        pc_src_i  = 1'b0;
        br_addr_i = 32'd0;
        mem_drop  = 1'b0;
        for (int k = 0; k < 128; k++) mem[k] = word(k);

        tick(); tick(); #1;
        chk_reset("rst");

        // Sequential fetch from BOOT
        RST_N = 1'b1; #1;
        chk_req("c0", 1'b1, 32'd0);
        chk("c0.valid", 32'(ifid_valid_o), 32'd0);
        tick(); #1; chk_req("c1", 1'b1, 32'd1); chk("c1.valid", 32'(ifid_valid_o), 32'd0);
        tick(); #1; chk_ifid("c2", 1'b1, word(0), 32'd4); chk_req("c2", 1'b1, 32'd2);
        tick(); #1; chk_ifid("c3", 1'b1, word(1), 32'd8);
        tick(); tick(); #1; chk_req("c5", 1'b1, 32'd5);

        // Stall for three cycles while word 5 returns
        tick(); stall_i = 1'b1; #1; chk_req("c6", 1'b0, 32'd0); chk_ifid("c6", 1'b1, word(4), 32'd20);
        tick(); #1; chk_req("c7", 1'b0, 32'd0); chk_ifid("c7", 1'b1, word(4), 32'd20);
        tick(); #1; chk_ifid("c8", 1'b1, word(4), 32'd20);
        tick(); stall_i = 1'b0; #1; chk_req("c9", 1'b0, 32'd0); chk_ifid("c9", 1'b1, word(4), 32'd20);
        tick(); #1; chk_ifid("c10", 1'b1, word(5), 32'd24); chk_req("c10", 1'b1, 32'd6);

        // Missing response for word 7
        tick(); mem_drop = 1'b1; #1; chk_ifid("c11", 1'b0, 32'h0, 32'h0); chk_req("c11", 1'b1, 32'd7);
        tick(); mem_drop = 1'b0; #1; chk_ifid("c12", 1'b1, word(6), 32'd28);
        tick(); #1; chk_ifid("c13", 1'b0, 32'h0, 32'h0); chk_req("c13", 1'b1, 32'd7);
        tick(); #1; chk_ifid("c14", 1'b0, 32'h0, 32'h0); chk_req("c14", 1'b1, 32'd8);
        tick(); #1; chk_ifid("c15", 1'b1, word(7), 32'd32);
        tick(); #1; chk_ifid("c16", 1'b1, word(8), 32'd36);

        // Redirect to unaligned 0x43 while word 10 returns
        tick(); pc_src_i = 1'b1; br_addr_i = 32'h0000_0043; #1;
        chk_ifid("c17", 1'b1, word(9), 32'd40);
        tick(); pc_src_i = 1'b0; #1; chk_ifid("c18", 1'b0, 32'h0, 32'h0); chk_req("c18", 1'b1, 32'd16);
        tick(); #1; chk_ifid("c19", 1'b0, 32'h0, 32'h0); chk_req("c19", 1'b1, 32'd17);
        tick(); #1; chk_ifid("c20", 1'b1, word(16), 32'h44);

        // Redirect and stall together
        tick(); pc_src_i = 1'b1; stall_i = 1'b1; br_addr_i = 32'h0000_0100; #1;
        chk_ifid("c21", 1'b1, word(17), 32'h48); chk_req("c21", 1'b0, 32'd0);
        tick(); pc_src_i = 1'b0; stall_i = 1'b0; #1;
        chk_ifid("c22", 1'b0, 32'h0, 32'h0); chk_req("c22", 1'b1, 32'd64);
        tick(); #1; chk_req("c23", 1'b1, 32'd65);
        tick(); stall_i = 1'b1; #1; chk_ifid("c24", 1'b1, word(64), 32'h104); chk_req("c24", 1'b0, 32'd0);
        tick(); #1; chk_ifid("c25", 1'b1, word(64), 32'h104);

        // Asynchronous reset with the skid entry occupied
        #1; RST_N = 1'b0; #1;
        chk_reset("arst");
        stall_i = 1'b0;
        tick(); tick(); RST_N = 1'b1; #1;
        chk_req("r0", 1'b1, 32'd0);
        tick(); #1; chk_req("r1", 1'b1, 32'd1); chk("r1.valid", 32'(ifid_valid_o), 32'd0);

        // PC wrap from the top of the address space
        tick(); pc_src_i = 1'b1; br_addr_i = 32'hFFFF_FFFC; #1;
        chk_ifid("r2", 1'b1, word(0), 32'd4);
        tick(); pc_src_i = 1'b0; #1; chk_req("r3", 1'b1, 32'd127); chk_ifid("r3", 1'b0, 32'h0, 32'h0);
        tick(); #1; chk_req("r4", 1'b1, 32'd0);
        tick(); #1; chk_ifid("r5", 1'b1, word(127), 32'd0);
        tick(); #1; chk_ifid("r6", 1'b1, word(0), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
